// File: rtl/pc_ctrl_if.sv
// Decode-side and PC-side signals of the program-counter sequencer.
// The master drives the decode inputs and prog_ctr. The slave (pc_ctrl) drives the PC controls and status.
interface pc_ctrl_if #(parameter int D = 12);
    logic         start;
    logic [D-1:0] prog_ctr;
    logic         br_en;
    logic         br_cond;
    logic         call_en;
    logic         ret_en;
    logic [D-1:0] offset;
    logic         halt_req;
    logic         stall;
    logic         pc_reset;
    logic         reljump_en;
    logic [D-1:0] target;
    logic         done;
    logic         stack_err;
    logic [1:0]   state;

    modport master (
        output start, prog_ctr, br_en, br_cond, call_en, ret_en, offset, halt_req, stall,
        input  pc_reset, reljump_en, target, done, stack_err, state
    );

    modport slave (
        input  start, prog_ctr, br_en, br_cond, call_en, ret_en, offset, halt_req, stall,
        output pc_reset, reljump_en, target, done, stack_err, state
    );
endinterface

// File: rtl/pc_ctrl.sv
// Program-counter sequencer: increment / relative jump / hold, with call/return stack, stall and halt.
// PC controls are combinational from the current state and decode inputs, so there is no added latency.
// Stall holds the PC. HALT holds until start is asserted.
module pc_ctrl #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    pc_ctrl_if.slave  bus
);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t         st;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_m1;
    logic [D-1:0]   stack [DEPTH];
    logic           done_q;
    logic           err_q;

    assign sp_m1         = sp - 1'b1;
    assign bus.state     = st;
    assign bus.done      = done_q;
    assign bus.stack_err = err_q;

    // Hold is encoded as a relative jump by zero, because PC has no hold input.
    always_comb begin
        bus.pc_reset   = 1'b0;
        bus.reljump_en = 1'b1;
        bus.target     = '0;
        case (st)
            IDLE: bus.pc_reset = 1'b1;
            RUN: begin
                if (bus.stall || bus.halt_req) begin
                    bus.target = '0;
                end else if (bus.ret_en) begin
                    if (sp != '0)
                        bus.target = stack[sp_m1[AW-1:0]] - bus.prog_ctr;
                end else if (bus.call_en) begin
                    if (sp != SP_FULL)
                        bus.target = bus.offset;
                end else if (bus.br_en && bus.br_cond) begin
                    bus.target = bus.offset;
                end else begin
                    bus.reljump_en = 1'b0;
                end
            end
            default: bus.target = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= IDLE;
            sp     <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                stack[i] <= '0;
        end else begin
            case (st)
                IDLE: begin
                    sp <= '0;
                    if (bus.start)
                        st <= RUN;
                end
                RUN: begin
                    if (bus.stall) begin
                        st <= RUN;
                    end else if (bus.halt_req) begin
                        st     <= HALT;
                        done_q <= 1'b1;
                    end else if (bus.ret_en) begin
                        if (sp == '0) begin
                            err_q  <= 1'b1;
                            st     <= HALT;
                            done_q <= 1'b1;
                        end else begin
                            sp <= sp_m1;
                        end
                    end else if (bus.call_en) begin
                        if (sp == SP_FULL) begin
                            err_q  <= 1'b1;
                            st     <= HALT;
                            done_q <= 1'b1;
                        end else begin
                            stack[sp[AW-1:0]] <= bus.prog_ctr + 1'b1;
                            sp                <= sp + 1'b1;
                        end
                    end
                end
                default: begin
                    if (bus.start) begin
                        st     <= IDLE;
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: models the PC register and scoreboards the expected prog_ctr after each clock.
module tb_pc_ctrl;
    localparam int D = 12;

    logic clk = 1'b0;
    logic reset;
    logic [D-1:0] pc;
    int errors = 0;
    int checks = 0;
    logic [D-1:0] exp_q [$];

    pc_ctrl_if #(.D(D)) bus ();

    pc_ctrl #(.D(D), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Model of the external PC register.
    always @(posedge clk or posedge reset) begin
        if (reset)                pc <= '0;
        else if (bus.pc_reset)    pc <= '0;
        else if (bus.reljump_en)  pc <= pc + bus.target;
        else                      pc <= pc + 1'b1;
    end
    assign bus.prog_ctr = pc;

    task automatic clr();
        bus.start = 0; bus.br_en = 0; bus.br_cond = 0; bus.call_en = 0;
        bus.ret_en = 0; bus.offset = '0; bus.halt_req = 0; bus.stall = 0;
    endtask

    task automatic cyc(input logic [D-1:0] exp_pc);
        logic [D-1:0] e;
        exp_q.push_back(exp_pc);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        checks++;
        if (bus.prog_ctr !== e) begin
            errors++;
            $display("FAIL pc got %h want %h at %0t", bus.prog_ctr, e, $time);
        end
    endtask

    task automatic goto(input logic [D-1:0] addr);
        bus.br_en = 1; bus.br_cond = 1; bus.offset = addr - pc;
        cyc(addr);
        clr();
    endtask

    task automatic restart();
        clr();
        bus.start = 1;
        cyc(12'h000);
        clr();
    endtask

    task automatic leave_halt();
        logic [D-1:0] hold_pc;
        hold_pc = pc;
        bus.start = 1;
        cyc(hold_pc);
        clr();
        checks++;
        if (bus.state !== 2'd0 || bus.stack_err !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL leave_halt state=%0d err=%b done=%b want 0 0 0", bus.state, bus.stack_err, bus.done);
        end
    endtask

    task automatic test_reset();
        clr();
        reset = 1;
        #12;
        checks++;
        if (bus.pc_reset !== 1 || bus.reljump_en !== 1 || bus.target !== 0 || bus.done !== 0 || bus.state !== 0) begin
            errors++;
            $display("FAIL reset_outs pc_reset=%b rj=%b tgt=%h done=%b st=%0d want 1 1 0 0 0",
                     bus.pc_reset, bus.reljump_en, bus.target, bus.done, bus.state);
        end
        @(negedge clk); reset = 0;
        for (int i = 0; i < 3; i++) cyc(12'h000);
        checks++;
        if (bus.pc_reset !== 1'b1) begin
            errors++;
            $display("FAIL idle_pc_reset got %b want 1", bus.pc_reset);
        end
        bus.start = 1;
        cyc(12'h000);
        bus.start = 0;
        checks++;
        if (bus.state !== 2'd1) begin
            errors++;
            $display("FAIL start_state got %0d want 1", bus.state);
        end
        cyc(12'h001); cyc(12'h002); cyc(12'h003);
    endtask

    task automatic test_branch();
        goto(12'h005);
        bus.br_en = 1; bus.br_cond = 1; bus.offset = 12'hFFD;
        cyc(12'h002); clr();
        goto(12'h005);
        bus.br_en = 1; bus.br_cond = 0; bus.offset = 12'hFFD;
        cyc(12'h006); clr();
        goto(12'h005);
        bus.br_en = 1; bus.br_cond = 1; bus.offset = 12'h000;
        cyc(12'h005); cyc(12'h005); clr();
        checks++;
        if (bus.state !== 2'd1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL self_loop state=%0d done=%b want 1 0", bus.state, bus.done);
        end
    endtask

    task automatic test_call_ret();
        goto(12'h010);
        bus.call_en = 1; bus.offset = 12'h100;
        cyc(12'h110); clr();
        checks++;
        if (dut.sp !== 1) begin errors++; $display("FAIL call_sp got %0d want 1", dut.sp); end
        bus.ret_en = 1;
        cyc(12'h011); clr();
        checks++;
        if (dut.sp !== 0) begin errors++; $display("FAIL ret_sp got %0d want 0", dut.sp); end
        goto(12'hFFF);
        bus.call_en = 1; bus.offset = 12'h100;
        cyc(12'h0FF); clr();
        bus.ret_en = 1;
        #1;
        checks++;
        if (bus.target !== 12'hF01) begin
            errors++;
            $display("FAIL ret_target got %h want f01", bus.target);
        end
        cyc(12'h000); clr();
    endtask

    task automatic test_overflow();
        logic [D-1:0] p;
        goto(12'h020);
        for (int i = 0; i < 4; i++) begin
            p = pc;
            bus.call_en = 1; bus.offset = 12'h001;
            cyc(p + 12'h001);
        end
        p = pc;
        cyc(p); clr();
        checks++;
        if (bus.stack_err !== 1 || bus.state !== 2'd2 || bus.done !== 1) begin
            errors++;
            $display("FAIL overflow err=%b state=%0d done=%b want 1 2 1", bus.stack_err, bus.state, bus.done);
        end
        cyc(p);
        leave_halt();
        restart();
        bus.ret_en = 1;
        cyc(12'h000); clr();
        checks++;
        if (bus.stack_err !== 1 || bus.state !== 2'd2) begin
            errors++;
            $display("FAIL underflow err=%b state=%0d want 1 2", bus.stack_err, bus.state);
        end
        leave_halt();
        restart();
    endtask

    task automatic test_stall_priority();
        goto(12'h007);
        bus.stall = 1; bus.call_en = 1; bus.offset = 12'h050;
        for (int i = 0; i < 3; i++) cyc(12'h007);
        clr();
        checks++;
        if (dut.sp !== 0) begin errors++; $display("FAIL stall_sp got %0d want 0", dut.sp); end
        cyc(12'h008);
        goto(12'h020);
        bus.call_en = 1; bus.offset = 12'h010;
        cyc(12'h030); cyc(12'h040);
        checks++;
        if (dut.sp !== 2) begin errors++; $display("FAIL two_calls_sp got %0d want 2", dut.sp); end
        bus.ret_en = 1;
        cyc(12'h031); clr();
        checks++;
        if (dut.sp !== 1) begin errors++; $display("FAIL call_ret_sp got %0d want 1", dut.sp); end
    endtask

    task automatic test_halt();
        goto(12'h009);
        bus.halt_req = 1;
        cyc(12'h009); clr();
        checks++;
        if (bus.done !== 1 || bus.state !== 2'd2) begin
            errors++;
            $display("FAIL halt done=%b state=%0d want 1 2", bus.done, bus.state);
        end
        bus.br_en = 1; bus.br_cond = 1; bus.offset = 12'h003; bus.call_en = 1;
        for (int i = 0; i < 5; i++) cyc(12'h009);
        clr();
        leave_halt();
        restart();
    endtask

    task automatic test_mid_reset();
        goto(12'h040);
        bus.call_en = 1; bus.offset = 12'h100;
        cyc(12'h140);
        #2;
        reset = 1;
        #1;
        checks++;
        if (bus.pc_reset !== 1 || bus.reljump_en !== 1 || bus.target !== 0 || bus.state !== 0 || bus.done !== 0) begin
            errors++;
            $display("FAIL mid_reset pc_reset=%b rj=%b tgt=%h st=%0d done=%b want 1 1 0 0 0",
                     bus.pc_reset, bus.reljump_en, bus.target, bus.state, bus.done);
        end
        checks++;
        if (dut.sp !== 0 || bus.stack_err !== 0) begin
            errors++;
            $display("FAIL mid_reset_sp sp=%0d err=%b want 0 0", dut.sp, bus.stack_err);
        end
        clr();
        cyc(12'h000);
        @(negedge clk); reset = 0;
        cyc(12'h000);
        restart();
        cyc(12'h001);
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_overflow();
        test_stall_priority();
        test_halt();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Sequencing controller for the relative-jump program counter (`PC`). Each cycle it decides whether the PC advances by one, jumps by a signed offset, or holds. It supports conditional branches, call/return through a small hardware return-address stack, stall, and halt. It sits between instruction decode and `PC`: it drives `PC`'s `reset`, `reljump_en` and `target` inputs and reads back `prog_ctr`.

## Interface
- `D`, 12, PC/address width; must match `PC`'s `D`.
- `DEPTH`, 4, return-stack entries; power of two, 2..16.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; reset is asynchronous and active-high.
- `start`  in  1  leave IDLE → RUN; in HALT, go to IDLE.
- `prog_ctr`  in  D  current PC value from `PC`.
- `br_en`  in  1  decoded conditional relative branch.
- `br_cond`  in  1  branch condition flag; branch taken iff `br_en & br_cond`.
- `call_en`  in  1  decoded call: push return address, jump relative.
- `ret_en`  in  1  decoded return: pop, jump to popped address.
- `offset`  in  D  two's-complement relative offset for branch/call.
- `halt_req`  in  1  decoded halt instruction.
- `stall`  in  1  hold PC this cycle (multi-cycle op in progress).
- `pc_reset`  out  1  drives `PC.reset`.
- `reljump_en`  out  1  drives `PC.reljump_en`.
- `target`  out  D  drives `PC.target`.
- `done`  out  1  high while in HALT.
- `stack_err`  out  1  sticky over/underflow flag.
- `state`  out  2  IDLE=0, RUN=1, HALT=2 (3 unused, decoded as HALT).

## Operation
- **Hold encoding:** because `PC` has no hold input, a hold is `reljump_en=1`, `target=0`.
- **IDLE:** `pc_reset=1`, hold encoding, `done=0`. Stack pointer `sp` is cleared every IDLE cycle.
  - `start=1` → RUN. Otherwise stay in IDLE.
- **RUN:** `pc_reset=0`. Decode inputs are evaluated with fixed priority; the first match wins:
  1. `stall` → hold. No state or stack change.
  2. `halt_req` → hold; next state HALT.
  3. `ret_en`:
     - If `sp==0`: underflow; set `stack_err`, hold, go to HALT.
     - Otherwise: pop; `target = stack[sp-1] - prog_ctr` (mod 2^D), `reljump_en=1`.
  4. `call_en`:
     - If `sp==DEPTH`: overflow; set `stack_err`, hold, go to HALT.
     - Otherwise: push `prog_ctr+1` (mod 2^D); `target=offset`, `reljump_en=1`.
  5. `br_en & br_cond` → `target=offset`, `reljump_en=1`.
  6. Otherwise (including a branch not taken) → `reljump_en=0`, `target=0`; the PC increments.
- **HALT:** hold encoding, `done=1`, `pc_reset=0`.
  - `start=1` → IDLE.
  - Other inputs are ignored.
- **Arithmetic:** all arithmetic is D-bit and wraps modulo 2^D. No overflow detection on address math.
- **Simultaneous decode inputs:** only the highest-priority input acts. Example: `call_en & ret_en` → return only, and `sp` decrements by exactly 1.
- **Branch to self:** a taken branch with `offset=0` is a legal self-loop and is not treated as a halt.
- **`stack_err`:** set on over/underflow. Cleared by `reset` or on the HALT→IDLE transition.
- **Stack entries:** reset to 0; they are not cleared on entering IDLE.

## Timing
- **Reset values** while `reset` is asserted (asynchronous):
  - state=IDLE, `sp=0`, `stack_err=0`, all stack entries 0.
  - Outputs: `pc_reset=1`, `reljump_en=1`, `target=0`, `done=0`, `state=0`.
- **Output path:** `pc_reset`, `reljump_en` and `target` are combinational from the current state, the decode inputs and `prog_ctr`. They are consumed by `PC` at the same edge, so the jump takes effect on `prog_ctr` one cycle after the decoded instruction is presented. Zero added latency.
- **Registered signals:** `state`, `done`, `stack_err` and `sp` update on the rising edge. `done` rises the cycle after `halt_req` is accepted.
- **IDLE→RUN:** the first fetch after `start` is at PC=0, since `PC` was held in reset throughout IDLE.
- **Mid-operation reset:** asserting `reset` mid-call or mid-stall returns to IDLE immediately. No partial push or pop is retained.
- **Stack bookkeeping:** push and pop each complete in one cycle; `sp` is valid the next cycle.

## Test plan
- **Reset/start:** assert `reset`, release, hold IDLE 3 cycles → `prog_ctr=0`, `pc_reset=1`. Pulse `start` → `prog_ctr` = 0, 1, 2, 3 on successive cycles.
- **Branch:** at `prog_ctr=5`:
  - `br_en=1`, `br_cond=1`, `offset=0xFFD` (−3) → next `prog_ctr=2`.
  - Same with `br_cond=0` → next `prog_ctr=6`.
  - `offset=0` taken → `prog_ctr` stays at 5.
- **Call/return:** at `prog_ctr=0x010`, `call_en`, `offset=0x100` → `prog_ctr=0x110`, `sp=1`. Then `ret_en` at `0x110` → `prog_ctr=0x011`, `sp=0`. Also repeat the call at `prog_ctr=0xFFF` → return lands at `0x000` (wrap).
- **Overflow/underflow:**
  - 5 nested calls with `DEPTH=4` → 5th sets `stack_err=1`, `state=HALT`, PC unchanged.
  - From fresh RUN, `ret_en` → `stack_err=1`, HALT.
  - `start` in HALT → IDLE, `stack_err=0`.
- **Stall/priority:**
  - `stall` held 3 cycles at `prog_ctr=7` → `prog_ctr` stays 7, then resumes at 8.
  - `call_en` and `ret_en` together with `sp=2` → return taken, `sp=1`.
- **Halt/mid-op reset:**
  - `halt_req` at `prog_ctr=9` → `done=1` next cycle, `prog_ctr` frozen at 9 indefinitely.
  - Assert `reset` asynchronously during a call cycle → outputs return to reset values immediately, `sp=0`.
